// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and IMEM write port shared between the program source and the encoder/loader.
interface instr_encoder_loader_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [5:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [N-1:0]      mem_wdata;

  modport master (
    output in_valid, fmt, op, rs, rt, rd, shamt, funct, imm, addr,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, fmt, op, rs, rt, rd, shamt, funct, imm, addr,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded R/I/J instruction fields into 32-bit MIPS words and streams them into IMEM.
//   state | meaning
//   IDLE  | after reset, waiting for start; no bundles accepted
//   LOAD  | accepting bundles, one IMEM write per legal bundle
//   FULL  | DEPTH words written; bundles ignored until start
module instr_encoder_loader #(
  parameter int N      = 32,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]     word_count,
  output logic                full,
  output logic                err
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [N-1:0]      packed_word;
  logic              accept;

  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    packed_word = '0;
    case (bus.fmt)
      2'b00:   packed_word = {bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      2'b01:   packed_word = {bus.op, bus.rs, bus.rt, bus.imm};
      2'b10:   packed_word = {bus.op, bus.addr};
      default: packed_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      word_count    <= '0;
      full          <= 1'b0;
      err           <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      // start wins over a simultaneous handshake; an already-registered strobe still completes
      if (start) begin
        state        <= LOAD;
        ptr          <= '0;
        word_count   <= '0;
        full         <= 1'b0;
        err          <= 1'b0;
        bus.in_ready <= 1'b1;
      end else if (accept && state == LOAD) begin
        if (bus.fmt == 2'b11) begin
          err <= 1'b1;
        end else begin
          bus.mem_we    <= 1'b1;
          bus.mem_addr  <= ptr;
          bus.mem_wdata <= packed_word;
          ptr           <= ptr + PTR_ONE;
          word_count    <= word_count + CNT_ONE;
          if (word_count == LAST_CNT) begin
            state        <= FULL;
            full         <= 1'b1;
            bus.in_ready <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader built with ADDR_W=2 so the full/wrap path is reachable.
module tb_instr_encoder_loader;
  localparam int N      = 32;
  localparam int ADDR_W = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [ADDR_W:0]  word_count;
  logic             full;
  logic             err;
  int               checks;
  int               failures;

  instr_encoder_loader_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .word_count (word_count),
    .full       (full),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] im, input logic [25:0] ad);
    bus.fmt = f; bus.op = o; bus.rs = s; bus.rt = t; bus.rd = d;
    bus.shamt = sh; bus.funct = fn; bus.imm = im; bus.addr = ad;
  endtask

  task automatic drive_r_add;
    drive(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hffff, 26'h3ffffff);
  endtask

  task automatic drive_i_addi;
    drive(2'b01, 6'h08, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3f, 16'h0005, 26'h3ffffff);
  endtask

  task automatic drive_j;
    drive(2'b10, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hffff, 26'h0100000);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 2'd0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", bus.mem_wdata); end
    checks++; if (word_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", word_count); end
    checks++; if (full !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_flags got full=%0b err=%0b exp 0 0", full, err); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_r_add();
    bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL idle_ignore got we=%0b ready=%0b exp 0 0", bus.mem_we, bus.in_ready); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_r_type;
    pulse_start();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL load_ready got=%0b exp=1", bus.in_ready); end
    drive_r_add();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL r_we got=%0b exp=1", bus.mem_we); end
    checks++; if (bus.mem_addr !== 2'd0) begin failures++; $display("FAIL r_addr got=%0d exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h00221820) begin failures++; $display("FAIL r_wdata got=%h exp=00221820", bus.mem_wdata); end
    checks++; if (word_count !== 3'd1) begin failures++; $display("FAIL r_count got=%0d exp=1", word_count); end
    tick();
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h00221820) begin failures++; $display("FAIL r_hold got we=%0b wdata=%h exp 0 00221820", bus.mem_we, bus.mem_wdata); end
  endtask

  task automatic test_back_to_back;
    drive_i_addi();
    bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 2'd1 || bus.mem_wdata !== 32'h20080005) begin
      failures++; $display("FAIL b2b_i got we=%0b addr=%0d wdata=%h exp 1 1 20080005", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    drive_j();
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 2'd2 || bus.mem_wdata !== 32'h08100000) begin
      failures++; $display("FAIL b2b_j got we=%0b addr=%0d wdata=%h exp 1 2 08100000", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    checks++; if (word_count !== 3'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", word_count); end
  endtask

  task automatic test_full;
    logic [31:0] exp_data [5];
    exp_data[0] = 32'h24000000; exp_data[1] = 32'h24010010; exp_data[2] = 32'h24020020;
    exp_data[3] = 32'h24030030; exp_data[4] = 32'h24040040;
    pulse_start();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, 6'h09, 5'd0, 5'(k), 5'd0, 5'd0, 6'd0, 16'(k * 16), 26'd0);
      tick();
      if (k < 4) begin
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 2'(k) || bus.mem_wdata !== exp_data[k]) begin
          failures++; $display("FAIL full_wr%0d got we=%0b addr=%0d wdata=%h exp 1 %0d %h", k, bus.mem_we, bus.mem_addr, bus.mem_wdata, k, exp_data[k]); end
      end else begin
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL full_5th_we got=%0b exp=0", bus.mem_we); end
      end
      if (k == 2) begin
        checks++; if (full !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL full_early got full=%0b ready=%0b exp 0 1", full, bus.in_ready); end
      end
      if (k >= 3) begin
        checks++; if (full !== 1'b1 || bus.in_ready !== 1'b0 || word_count !== 3'd4) begin
          failures++; $display("FAIL full_state%0d got full=%0b ready=%0b count=%0d exp 1 0 4", k, full, bus.in_ready, word_count); end
      end
    end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_we !== 1'b0 || word_count !== 3'd4 || bus.mem_addr !== 2'd3) begin
      failures++; $display("FAIL full_hold got we=%0b count=%0d addr=%0d exp 0 4 3", bus.mem_we, word_count, bus.mem_addr); end
  endtask

  task automatic test_illegal;
    pulse_start();
    checks++; if (full !== 1'b0 || word_count !== 3'd0) begin failures++; $display("FAIL ill_clear got full=%0b count=%0d exp 0 0", full, word_count); end
    bus.in_valid = 1'b1;
    drive_r_add();
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 2'd0 || err !== 1'b0) begin
      failures++; $display("FAIL ill_first got we=%0b addr=%0d err=%0b exp 1 0 0", bus.mem_we, bus.mem_addr, err); end
    drive(2'b11, 6'h3f, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3f, 16'h1234, 26'h1234567);
    tick();
    checks++; if (bus.mem_we !== 1'b0 || err !== 1'b1 || word_count !== 3'd1 || bus.mem_wdata !== 32'h00221820) begin
      failures++; $display("FAIL ill_bad got we=%0b err=%0b count=%0d wdata=%h exp 0 1 1 00221820", bus.mem_we, err, word_count, bus.mem_wdata); end
    drive_j();
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 2'd1 || bus.mem_wdata !== 32'h08100000) begin
      failures++; $display("FAIL ill_second got we=%0b addr=%0d wdata=%h exp 1 1 08100000", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    tick();
    checks++; if (err !== 1'b1 || word_count !== 3'd2) begin failures++; $display("FAIL ill_sticky got err=%0b count=%0d exp 1 2", err, word_count); end
  endtask

  task automatic test_start_priority;
    bus.in_valid = 1'b1;
    drive_i_addi();
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 2'd2) begin failures++; $display("FAIL sp_pre got we=%0b addr=%0d exp 1 2", bus.mem_we, bus.mem_addr); end
    drive_j();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (bus.mem_we !== 1'b0 || err !== 1'b0 || full !== 1'b0 || word_count !== 3'd0) begin
      failures++; $display("FAIL sp_start got we=%0b err=%0b full=%0b count=%0d exp 0 0 0 0", bus.mem_we, err, full, word_count); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 2'd0 || bus.mem_wdata !== 32'h08100000 || word_count !== 3'd1) begin
      failures++; $display("FAIL sp_next got we=%0b addr=%0d wdata=%h count=%0d exp 1 0 08100000 1", bus.mem_we, bus.mem_addr, bus.mem_wdata, word_count); end
  endtask

  task automatic test_async_reset;
    pulse_start();
    bus.in_valid = 1'b1;
    drive(2'b11, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    tick();
    drive_r_add();
    for (int k = 0; k < 4; k++) tick();
    checks++; if (bus.mem_we !== 1'b1 || full !== 1'b1 || err !== 1'b1 || word_count !== 3'd4) begin
      failures++; $display("FAIL ar_pre got we=%0b full=%0b err=%0b count=%0d exp 1 1 1 4", bus.mem_we, full, err, word_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || full !== 1'b0 || err !== 1'b0 || word_count !== 3'd0 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL ar_async got we=%0b full=%0b err=%0b count=%0d ready=%0b exp 0 0 0 0 0", bus.mem_we, full, err, word_count, bus.in_ready); end
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.mem_addr !== 2'd0 || bus.mem_wdata !== 32'h0) begin
      failures++; $display("FAIL ar_idle got ready=%0b addr=%0d wdata=%h exp 0 0 0", bus.in_ready, bus.mem_addr, bus.mem_wdata); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    bus.in_valid = 1'b0;
    drive(2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    test_reset();
    test_r_type();
    test_back_to_back();
    test_full();
    test_illegal();
    test_start_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
